// File: rtl/perf_counter_bank.sv
// perf_counter_bank: per-channel event counters plus a cycle counter, gated by an IDLE/RUN/FROZEN FSM
// Ports: clk; rst (sync, active-high); en starts/continues counting; events[NUM_CH] per-channel strobes;
//        halt freezes the counts; clr zeroes counters, flags and state; rd_req/rd_sel request a read
//        (rd_sel 7 = cycle counter); rd_valid/rd_data/rd_ovf return it one cycle later; state = FSM.
// Option: PERF_CNT_SAT_EN selects saturating counters; default wraps with a sticky overflow flag.
module perf_counter_bank #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] events,
    input  logic              halt,
    input  logic              clr,
    input  logic              rd_req,
    input  logic [2:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_ovf,
    output logic [1:0]        state
);
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] RUN    = 2'b01;
    localparam logic [1:0] FROZEN = 2'b10;
    localparam int N = NUM_CH + 1;
    localparam logic [CNT_W-1:0] ONES = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [N-1:0]     ovf_q, ovf_d;
    logic [N-1:0]     inc;
    logic [CNT_W-1:0] tab [8];
    logic [7:0]       tab_ovf;
    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_ovf_q;

    // Top slot (index N-1) is the cycle counter, which ticks whenever counting is enabled
    assign inc = {N{state_q == RUN && en}} & {1'b1, events};

    always_comb begin
        state_d = clr ? IDLE
                : (state_q == IDLE && en) ? RUN
                : (state_q == RUN && halt) ? FROZEN
                : (state_q == 2'b11) ? IDLE : state_q;
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k];
            if (clr) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end else if (inc[k]) begin
`ifdef PERF_CNT_SAT_EN
                cnt_d[k] = (cnt_q[k] == ONES) ? ONES : cnt_q[k] + 1'b1;
                ovf_d[k] = ovf_q[k] | (cnt_q[k] >= ONES - 1'b1);
`else
                cnt_d[k] = cnt_q[k] + 1'b1;
                ovf_d[k] = ovf_q[k] | (cnt_q[k] == ONES);
`endif
            end
        end
    end

    // Fixed 8-entry read table: channels below NUM_CH, zeros up to 6, cycle counter at 7
    for (genvar i = 0; i < 8; i++) begin : g_tab
        if (i == 7) begin : g_cyc
            assign tab[i]     = cnt_q[N-1];
            assign tab_ovf[i] = ovf_q[N-1];
        end else if (i < NUM_CH) begin : g_ch
            assign tab[i]     = cnt_q[i];
            assign tab_ovf[i] = ovf_q[i];
        end else begin : g_none
            assign tab[i]     = '0;
            assign tab_ovf[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int k = 0; k < N; k++) cnt_q[k] <= '0;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= tab[rd_sel];
                rd_ovf_q  <= tab_ovf[rd_sel];
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_ovf   = rd_ovf_q;
    assign state    = state_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed and random checks of perf_counter_bank against a total-count model
module tb_perf_counter_bank;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int MAXV   = (1 << CNT_W) - 1;
`ifdef PERF_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, en, halt, clr, rd_req;
    logic [NUM_CH-1:0] events;
    logic [2:0]        rd_sel;
    logic              rd_valid, rd_ovf;
    logic [CNT_W-1:0]  rd_data;
    logic [1:0]        state;

    int n_checks = 0;
    int n_pass = 0;

    // Model keeps the unbounded number of counted increments per slot; slot 7 is the cycle count
    int               tot [8];
    logic [1:0]       m_state;
    logic             m_valid, m_ovf;
    logic [CNT_W-1:0] m_data;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .events(events), .halt(halt), .clr(clr),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_ovf(rd_ovf), .state(state)
    );

    function automatic logic [CNT_W-1:0] m_val(int t);
        return CNT_W'(SAT ? (t >= MAXV ? MAXV : t) : t % (MAXV + 1));
    endfunction

    function automatic logic m_flag(int t);
        return SAT ? (t >= MAXV) : (t > MAXV);
    endfunction

    task automatic model_edge();
        if (rst) begin
            foreach (tot[k]) tot[k] = 0;
            m_state = 2'b00;
            m_valid = 1'b0;
            m_data = '0;
            m_ovf = 1'b0;
            return;
        end
        m_valid = rd_req;
        if (rd_req) begin
            if (rd_sel == 3'd7 || int'(rd_sel) < NUM_CH) begin
                m_data = m_val(tot[rd_sel]);
                m_ovf = m_flag(tot[rd_sel]);
            end else begin
                m_data = '0;
                m_ovf = 1'b0;
            end
        end
        if (clr) begin
            foreach (tot[k]) tot[k] = 0;
            m_state = 2'b00;
        end else begin
            if (m_state == 2'b01 && en) begin
                tot[7]++;
                for (int k = 0; k < NUM_CH; k++) if (events[k]) tot[k]++;
            end
            m_state = (m_state == 2'b00 && en) ? 2'b01 : (m_state == 2'b01 && halt) ? 2'b10 : m_state;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_in();
        rst = 0; en = 0; events = '0; halt = 0; clr = 0; rd_req = 0; rd_sel = 3'd0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (state !== 2'b00) $display("FAIL reset_state got=%b exp=00", state); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", rd_valid); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_data got=%h exp=0", rd_data); else n_pass++;
        n_checks++; if (rd_ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", rd_ovf); else n_pass++;
        for (int s = 0; s < 8; s++) begin
            rd_req = 1; rd_sel = 3'(s);
            tick();
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== '0) $display("FAIL reset_read sel=%0d valid=%b data=%h exp valid=1 data=0", s, rd_valid, rd_data); else n_pass++;
        end
        idle_in();
    endtask

    task automatic test_run_halt();
        do_reset();
        en = 1;
        tick();
        n_checks++; if (state !== 2'b01) $display("FAIL run_enter got=%b exp=01", state); else n_pass++;
        for (int c = 0; c <= 10; c++) begin
            events = (c < 5) ? NUM_CH'(1) : '0;
            halt = (c == 10);
            tick();
        end
        n_checks++; if (state !== 2'b10) $display("FAIL halt_frozen got=%b exp=10", state); else n_pass++;
        events = '1; halt = 1; en = 1; rd_req = 1; rd_sel = 3'd0;
        tick();
        n_checks++; if (rd_data !== 8'd5) $display("FAIL halt_ch0 got=%0d exp=5", rd_data); else n_pass++;
        rd_sel = 3'd7;
        tick();
        n_checks++; if (rd_data !== 8'd11) $display("FAIL halt_cyc got=%0d exp=11", rd_data); else n_pass++;
        tick();
        tick();
        n_checks++; if (rd_data !== 8'd11 || state !== 2'b10) $display("FAIL frozen_hold data=%0d state=%b exp data=11 state=10", rd_data, state); else n_pass++;
        idle_in();
    endtask

    task automatic test_clr_priority();
        do_reset();
        en = 1;
        tick();
        events = NUM_CH'(4);
        repeat (3) tick();
        clr = 1; rd_req = 1; rd_sel = 3'd2;
        tick();
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 8'd3) $display("FAIL clr_preval valid=%b data=%0d exp valid=1 data=3", rd_valid, rd_data); else n_pass++;
        n_checks++; if (state !== 2'b00) $display("FAIL clr_state got=%b exp=00", state); else n_pass++;
        idle_in();
        rd_req = 1; rd_sel = 3'd2;
        tick();
        n_checks++; if (rd_data !== '0 || rd_ovf !== 1'b0) $display("FAIL clr_ch2 data=%0d ovf=%b exp 0/0", rd_data, rd_ovf); else n_pass++;
        rd_sel = 3'd7;
        tick();
        n_checks++; if (rd_data !== '0) $display("FAIL clr_cyc got=%0d exp=0", rd_data); else n_pass++;
        idle_in();
    endtask

    task automatic test_overflow();
        logic [CNT_W-1:0] exp_v;
        exp_v = SAT ? 8'hFF : 8'h04;
        do_reset();
        en = 1;
        tick();
        events = NUM_CH'(2);
        repeat (260) tick();
        idle_in();
        tick();
        n_checks++; if (state !== 2'b01) $display("FAIL pause_state got=%b exp=01", state); else n_pass++;
        rd_req = 1; rd_sel = 3'd1;
        tick();
        n_checks++; if (rd_data !== exp_v || rd_ovf !== 1'b1) $display("FAIL ovf_ch1 data=%h ovf=%b exp data=%h ovf=1", rd_data, rd_ovf, exp_v); else n_pass++;
        rd_sel = 3'd7;
        tick();
        n_checks++; if (rd_data !== exp_v || rd_ovf !== 1'b1) $display("FAIL ovf_cyc data=%h ovf=%b exp data=%h ovf=1", rd_data, rd_ovf, exp_v); else n_pass++;
        rd_sel = 3'd0;
        tick();
        n_checks++; if (rd_data !== '0 || rd_ovf !== 1'b0) $display("FAIL ovf_ch0 data=%h ovf=%b exp 0/0", rd_data, rd_ovf); else n_pass++;
        rd_req = 0; clr = 1;
        tick();
        clr = 0; rd_req = 1; rd_sel = 3'd1;
        tick();
        n_checks++; if (rd_data !== '0 || rd_ovf !== 1'b0) $display("FAIL ovf_clear data=%h ovf=%b exp 0/0", rd_data, rd_ovf); else n_pass++;
        idle_in();
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1;
        tick();
        for (int c = 0; c < 5; c++) begin
            events = NUM_CH'($urandom);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            events = NUM_CH'($urandom);
            rd_req = 1;
            rd_sel = (c == 0) ? 3'd0 : (c == 1) ? 3'd1 : 3'd7;
            tick();
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== m_data || rd_ovf !== m_ovf) $display("FAIL b2b_read%0d valid=%b data=%0d ovf=%b exp valid=1 data=%0d ovf=%b", c, rd_valid, rd_data, rd_ovf, m_data, m_ovf); else n_pass++;
        end
        n_checks++; if (rd_data !== 8'd7) $display("FAIL b2b_cyc got=%0d exp=7", rd_data); else n_pass++;
        rd_req = 0;
        tick();
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 8'd7) $display("FAIL b2b_hold valid=%b data=%0d exp valid=0 data=7", rd_valid, rd_data); else n_pass++;
        idle_in();
    endtask

    task automatic test_unused_sel();
        do_reset();
        en = 1;
        tick();
        events = '1;
        repeat (4) tick();
        for (int s = 3; s <= 6; s++) begin
            rd_req = 1; rd_sel = 3'(s);
            tick();
            n_checks++; if (rd_data !== m_data || rd_ovf !== m_ovf || (s > 3 && rd_data !== '0)) $display("FAIL sel%0d data=%0d ovf=%b exp data=%0d ovf=%b", s, rd_data, rd_ovf, m_data, m_ovf); else n_pass++;
        end
        idle_in();
    endtask

    task automatic test_rst_frozen();
        do_reset();
        en = 1;
        tick();
        events = '1;
        repeat (3) tick();
        halt = 1;
        tick();
        n_checks++; if (state !== 2'b10) $display("FAIL rstfz_frozen got=%b exp=10", state); else n_pass++;
        halt = 0; rd_req = 1; rd_sel = 3'd0;
        tick();
        rst = 1; rd_sel = 3'd7;
        tick();
        n_checks++; if (state !== 2'b00 || rd_valid !== 1'b0 || rd_data !== '0 || rd_ovf !== 1'b0) $display("FAIL rstfz_reset state=%b valid=%b data=%0d ovf=%b exp 00/0/0/0", state, rd_valid, rd_data, rd_ovf); else n_pass++;
        idle_in();
        for (int s = 0; s < 8; s++) begin
            rd_req = 1; rd_sel = 3'(s);
            tick();
            n_checks++; if (rd_valid !== 1'b1 || rd_data !== '0 || rd_ovf !== 1'b0) $display("FAIL rstfz_read sel=%0d valid=%b data=%0d ovf=%b exp 1/0/0", s, rd_valid, rd_data, rd_ovf); else n_pass++;
        end
        idle_in();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 49) == 0);
            halt = ($urandom_range(0, 39) == 0);
            en = ($urandom_range(0, 9) < 8);
            events = NUM_CH'($urandom);
            rd_req = 1'($urandom_range(0, 1));
            rd_sel = 3'($urandom);
            tick();
            n_checks++; if (state !== m_state) $display("FAIL rand_state cyc=%0d got=%b exp=%b", c, state, m_state); else n_pass++;
            n_checks++; if (rd_valid !== m_valid) $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, rd_valid, m_valid); else n_pass++;
            n_checks++; if (rd_data !== m_data) $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, rd_data, m_data); else n_pass++;
            n_checks++; if (rd_ovf !== m_ovf) $display("FAIL rand_ovf cyc=%0d got=%b exp=%b", c, rd_ovf, m_ovf); else n_pass++;
        end
        idle_in();
    endtask

    initial begin
        idle_in();
        test_reset();
        test_run_halt();
        test_clr_priority();
        test_overflow();
        test_back_to_back();
        test_unused_sel();
        test_rst_frozen();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, meaning the number of event counter channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of each counter and of the cycle counter (8..32).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port en, input, 1, meaning the start/continue counting enable.
REQ-006 SHALL have port events, input, NUM_CH, meaning per-channel single-cycle event strobes.
REQ-007 SHALL have port halt, input, 1, meaning the processor halted and counts freeze.
REQ-008 SHALL have port clr, input, 1, meaning the synchronous clear of all counters, overflow flags and state.
REQ-009 SHALL have port rd_req, input, 1, meaning the read request.
REQ-010 SHALL have port rd_sel, input, 3, meaning the channel index; value 7 selects the cycle counter.
REQ-011 SHALL have port rd_valid, output, 1, meaning read data is valid.
REQ-012 SHALL have port rd_data, output, CNT_W, meaning the read value.
REQ-013 SHALL have port rd_ovf, output, 1, meaning the overflow flag of the read channel.
REQ-014 SHALL have port state, output, 2, meaning the FSM state: 00 IDLE, 01 RUN, 10 FROZEN.

Function
REQ-015 SHALL move from IDLE to RUN on the cycle after en=1 is sampled; before that, no channel or cycle count is taken.
REQ-016 SHALL, in RUN with en=1, increment channel i by 1 per cycle in which events[i]=1, and the cycle counter by 1 every cycle.
REQ-017 SHALL, in RUN with en=0, hold all counters and remain in RUN (pause).
REQ-018 SHALL, on halt=1 in RUN, count that cycle's events and cycle, then enter FROZEN the next cycle.
REQ-019 SHALL hold all counters in FROZEN regardless of en, events or halt; the only exits are clr or rst.
REQ-020 SHALL, on clr=1, zero all counters and flags and enter IDLE next cycle; clr takes priority over any same-cycle event, halt or en.
REQ-021 SHALL, on rd_req=1, assert rd_valid exactly one cycle later with rd_data/rd_ovf equal to the selected counter's value before that cycle's increment.
REQ-022 SHALL accept rd_req every cycle (back-to-back reads give one rd_valid per request, in order), in any state.
REQ-023 SHALL return rd_data=0 and rd_ovf=0 for rd_sel values in NUM_CH..6.
REQ-024 SHALL drive rd_valid=0 and rd_data/rd_ovf held at their last value in cycles with no pending read.
REQ-025 SHALL, if clr and rd_req coincide, return pre-clear values.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, set state=IDLE, all counters=0, all overflow flags=0, rd_valid=0, rd_data=0, rd_ovf=0.
REQ-027 SHALL make rst dominant over clr, halt, en and rd_req; a read pending at reset is dropped.
REQ-028 SHALL honour reset asserted mid-RUN or mid-FROZEN identically to power-on reset.

Configuration
REQ-029 SHALL, with PERF_CNT_SAT_EN defined, saturate every counter at all-ones (further increments ignored) and set its overflow flag when it reaches all-ones.
REQ-030 SHALL, without PERF_CNT_SAT_EN, wrap each counter from all-ones to 0 and set a sticky overflow flag on the wrap; the flag clears only on clr/rst.

Verification
REQ-031 SHALL verify: rst, en=1 at cycle 0, events[0] high 5 cycles, halt at cycle 10 -> state FROZEN at cycle 11; read ch0=5, ch7 (cycle)=11.
REQ-032 SHALL verify: events[2] and clr high in the same cycle -> ch2=0, state IDLE next cycle.
REQ-033 SHALL verify: CNT_W=8, 260 events on ch1 -> with PERF_CNT_SAT_EN rd_data=0xFF, rd_ovf=1; without it rd_data=0x04, rd_ovf=1.
REQ-034 SHALL verify: rd_req 3 consecutive cycles with rd_sel=0,1,7 -> rd_valid high 3 consecutive cycles with the matching values in order.
REQ-035 SHALL verify: NUM_CH=4, rd_sel=5 -> rd_data=0, rd_ovf=0; and rst asserted in FROZEN -> state IDLE, all reads 0.
